efuse_macro_emu: RTL and testbench

Synthesizable responder model of the 256-bit eFuse macro, sitting on the far side of the controller's EFUSE pin interface (pgmen/rden/aen/addr in, 8-bit read data out). Used in FPGA prototypes and system simulation in place of the hard macro. It stores fuse state in flops, executes read and program pulses with macro-like latency and one-time-programmable semantics, and records protocol and timing violations in sticky flags.

---
 rtl/efuse_pkg.sv | 38 +++
 rtl/efuse_pulse_meter.sv | 35 +++
 rtl/efuse_macro_emu.sv | 177 +++++++++++++++++
 tb/tb_efuse_macro_emu.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse macro responder model.
// Fuse geometry, FSM states, access latch bundle and error flag indices.
package efuse_pkg;

  localparam int FUSE_BITS = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 10;
  localparam int ERR_W     = 4;
  localparam int BLOW_W    = 9;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int ERR_SHORT_PGM = 0;
  localparam int ERR_SHORT_RD  = 1;
  localparam int ERR_CONFLICT  = 2;
  localparam int ERR_UNSTABLE  = 3;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PROG,
    ERR_WAIT
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              pgmen;
    logic              rden;
  } access_t;

  function automatic logic [ADDR_W-1:0] byte_base(
    input logic [ADDR_W-1:0] addr
  );
    return {addr[ADDR_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/efuse_pulse_meter.sv
// Access strobe edge detector with a saturating high-time counter.
// cnt reads 1 in the cycle after the rise and keeps counting high cycles.
module efuse_pulse_meter
  import efuse_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             aen,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cnt
);

  logic             aen_q;
  logic [CNT_W-1:0] cnt_q;

  assign rise = aen & ~aen_q;
  assign fall = ~aen & aen_q;
  assign cnt  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aen_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      aen_q <= aen;
      if (rise) begin
        cnt_q <= CNT_W'(1);
      end else if (aen && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/efuse_macro_emu.sv
// Flop-based stand-in for the 256-bit eFuse hard macro.
// Serves read/program pulses with OTP semantics and sticky error flags.
module efuse_macro_emu
  import efuse_pkg::*;
#(
  parameter logic [9:0]           TPGM_MIN = 10'd65,
  parameter logic [5:0]           RD_LAT   = 6'd2,
  parameter logic [FUSE_BITS-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 efuse_pgmen_i,
  input  logic                 efuse_rden_i,
  input  logic                 efuse_aen_i,
  input  logic [ADDR_W-1:0]    efuse_addr_i,
  output logic [DATA_W-1:0]    efuse_rdata_o,
  input  logic                 err_clr,
  output logic [ERR_W-1:0]     err_flags,
  output logic                 prog_done,
  output logic [BLOW_W-1:0]    blow_cnt,
  output logic [FUSE_BITS-1:0] fuse_bits_o
);

  // A zero latency behaves like one: data lands in the cycle after rise.
  localparam logic [CNT_W-1:0] RD_EFF =
    (RD_LAT == 6'd0) ? CNT_W'(1) : CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] RD_HIT = RD_EFF - CNT_W'(1);
  localparam bit               RD_IMM = (RD_EFF == CNT_W'(1));

  state_e               state;
  access_t              acc;
  access_t              cur;
  logic                 rd_done;
  logic [FUSE_BITS-1:0] fuse;
  logic [DATA_W-1:0]    rdata_q;
  logic [ERR_W-1:0]     err_q;
  logic [ERR_W-1:0]     err_set;
  logic                 done_q;
  logic [BLOW_W-1:0]    blow_q;

  logic                 rise;
  logic                 fall;
  logic [CNT_W-1:0]     cnt;
  logic                 chg;
  logic                 long_pgm;
  logic [DATA_W-1:0]    cur_byte;
  logic [DATA_W-1:0]    acc_byte;

  efuse_pulse_meter u_meter (
    .clk   (clk),
    .rst_n (rst_n),
    .aen   (efuse_aen_i),
    .rise  (rise),
    .fall  (fall),
    .cnt   (cnt)
  );

  assign cur      = {efuse_addr_i, efuse_pgmen_i, efuse_rden_i};
  assign chg      = (cur != acc);
  assign long_pgm = (cnt >= TPGM_MIN);
  assign cur_byte = fuse[byte_base(efuse_addr_i) +: DATA_W];
  assign acc_byte = fuse[byte_base(acc.addr) +: DATA_W];

  assign efuse_rdata_o = rdata_q;
  assign err_flags     = err_q;
  assign prog_done     = done_q;
  assign blow_cnt      = blow_q;
  assign fuse_bits_o   = fuse;

  always_comb begin
    err_set = '0;
    unique case (state)
      IDLE: begin
        if (rise && efuse_pgmen_i && efuse_rden_i) begin
          err_set[ERR_CONFLICT] = 1'b1;
        end
      end
      READ: begin
        if (efuse_aen_i && chg) begin
          err_set[ERR_UNSTABLE] = 1'b1;
        end else if (fall && !rd_done) begin
          err_set[ERR_SHORT_RD] = 1'b1;
        end
      end
      PROG: begin
        if (efuse_aen_i && chg) begin
          err_set[ERR_UNSTABLE] = 1'b1;
        end else if (fall && !long_pgm) begin
          err_set[ERR_SHORT_PGM] = 1'b1;
        end
      end
      ERR_WAIT: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      rd_done <= 1'b0;
      fuse    <= INIT_VAL;
      rdata_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      blow_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // A new error in the clear cycle must survive the clear.
      err_q  <= (err_clr ? '0 : err_q) | err_set;
      unique case (state)
        IDLE: begin
          if (rise) begin
            unique case (1'b1)
              (efuse_pgmen_i & efuse_rden_i): begin
                state <= ERR_WAIT;
              end
              (efuse_rden_i & ~efuse_pgmen_i): begin
                acc     <= cur;
                rd_done <= RD_IMM;
                if (RD_IMM) begin
                  rdata_q <= cur_byte;
                end
                state   <= READ;
              end
              (efuse_pgmen_i & ~efuse_rden_i): begin
                acc   <= cur;
                state <= PROG;
              end
              default: begin
              end
            endcase
          end
        end
        READ: begin
          if (efuse_aen_i) begin
            if (chg) begin
              state <= ERR_WAIT;
            end else if (!rd_done && cnt == RD_HIT) begin
              rdata_q <= acc_byte;
              rd_done <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        PROG: begin
          if (efuse_aen_i) begin
            if (chg) begin
              state <= ERR_WAIT;
            end
          end else begin
            if (long_pgm) begin
              fuse[acc.addr] <= 1'b1;
              done_q         <= 1'b1;
              if (!fuse[acc.addr]) begin
                blow_q <= blow_q + BLOW_W'(1);
              end
            end
            state <= IDLE;
          end
        end
        ERR_WAIT: begin
          if (!efuse_aen_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_efuse_macro_emu.sv
// Randomised bench for efuse_macro_emu against an access-level model.
// Each access is described by kind, address, high time and glitch cycle.
module tb_efuse_macro_emu;

  localparam logic [255:0] INIT = 256'hA5;
  localparam int           RDL  = 2;
  localparam int           TPG  = 65;

  logic         clk;
  logic         rst_n;
  logic         efuse_pgmen_i;
  logic         efuse_rden_i;
  logic         efuse_aen_i;
  logic [7:0]   efuse_addr_i;
  logic [7:0]   efuse_rdata_o;
  logic         err_clr;
  logic [3:0]   err_flags;
  logic         prog_done;
  logic [8:0]   blow_cnt;
  logic [255:0] fuse_bits_o;

  efuse_macro_emu #(
    .TPGM_MIN (10'(TPG)),
    .RD_LAT   (6'(RDL)),
    .INIT_VAL (INIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .efuse_pgmen_i (efuse_pgmen_i),
    .efuse_rden_i  (efuse_rden_i),
    .efuse_aen_i   (efuse_aen_i),
    .efuse_addr_i  (efuse_addr_i),
    .efuse_rdata_o (efuse_rdata_o),
    .err_clr       (err_clr),
    .err_flags     (err_flags),
    .prog_done     (prog_done),
    .blow_cnt      (blow_cnt),
    .fuse_bits_o   (fuse_bits_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] m_fuse;
  int           m_blow;
  logic [3:0]   m_err;
  logic [7:0]   m_rdata;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".fuse"}, fuse_bits_o, m_fuse);
    check({tag, ".blow"}, 256'(blow_cnt), 256'(m_blow));
    check({tag, ".err"}, 256'(err_flags), 256'(m_err));
    check({tag, ".rdata"}, 256'(efuse_rdata_o), 256'(m_rdata));
  endtask

  // kind: 0 read, 1 program, 2 both enables, 3 no enable.
  // k > 0 flips the address at the k-th high cycle.
  task automatic access(input int kind, input logic [7:0] a, input int hi,
                        input int k, input bit clr_rise);
    logic [7:0] old_rd;
    logic [7:0] new_rd;
    bit         upd;
    bit         done;
    int         b;
    old_rd = m_rdata;
    upd    = 0;
    done   = 0;
    b      = int'(a) / 8 * 8;
    if (clr_rise) m_err = '0;
    case (kind)
      0: begin
        if (k > 0) begin
          m_err[3] = 1'b1;
          upd      = (k >= RDL);
        end else if (hi >= RDL) begin
          upd = 1;
        end else begin
          m_err[1] = 1'b1;
        end
      end
      1: begin
        if (k > 0) m_err[3] = 1'b1;
        else if (hi >= TPG) done = 1;
        else m_err[0] = 1'b1;
      end
      2: m_err[2] = 1'b1;
      default: ;
    endcase
    new_rd = upd ? m_fuse[b +: 8] : old_rd;
    if (done) begin
      if (!m_fuse[a]) m_blow++;
      m_fuse[a] = 1'b1;
    end
    efuse_addr_i  = a;
    efuse_pgmen_i = (kind == 1 || kind == 2);
    efuse_rden_i  = (kind == 0 || kind == 2);
    efuse_aen_i   = 1'b1;
    err_clr       = clr_rise;
    for (int i = 0; i < hi; i++) begin
      if (k > 0 && i == k) efuse_addr_i = a ^ 8'h41;
      tick();
      err_clr = 1'b0;
      if (kind == 0 && i + 1 == RDL - 1)
        check("rd_early", 256'(efuse_rdata_o), 256'(old_rd));
      if (kind == 0 && i + 1 == RDL)
        check("rd_lat", 256'(efuse_rdata_o), 256'(new_rd));
    end
    efuse_aen_i = 1'b0;
    tick();
    efuse_pgmen_i = 1'b0;
    efuse_rden_i  = 1'b0;
    m_rdata       = new_rd;
    check("prog_done", 256'(prog_done), 256'(done));
    check_outs("post");
    tick();
    check("done_pulse", 256'(prog_done), 256'(0));
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err   = '0;
    check("err_clr", 256'(err_flags), 256'(0));
  endtask

  task automatic model_reset();
    m_fuse  = INIT;
    m_blow  = 0;
    m_err   = '0;
    m_rdata = '0;
  endtask

  initial begin
    int kind;
    int hi;
    int k;
    int sel;
    logic [7:0] a;
    rst_n         = 1'b0;
    efuse_pgmen_i = 1'b0;
    efuse_rden_i  = 1'b0;
    efuse_aen_i   = 1'b0;
    efuse_addr_i  = '0;
    err_clr       = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst.done", 256'(prog_done), 256'(0));
    check_outs("rst");
    rst_n = 1'b1;
    tick();

    access(0, 8'h00, 4, 0, 0);
    access(1, 8'd13, 65, 0, 0);
    access(0, 8'h08, 3, 0, 0);
    access(1, 8'd13, 65, 0, 0);
    access(1, 8'd20, 64, 0, 0);
    clear_errs();
    access(2, 8'h10, 10, 0, 0);
    access(0, 8'h08, 3, 0, 0);
    access(1, 8'd33, 80, 30, 0);
    access(0, 8'h00, 1, 0, 0);
    access(2, 8'h20, 3, 0, 1);
    access(3, 8'h08, 4, 0, 0);
    access(1, 8'd255, 66, 0, 0);
    access(0, 8'hFF, 2, 0, 0);

    efuse_addr_i  = 8'd77;
    efuse_pgmen_i = 1'b1;
    efuse_aen_i   = 1'b1;
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst.done", 256'(prog_done), 256'(0));
    check_outs("mid_rst");
    efuse_aen_i   = 1'b0;
    efuse_pgmen_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    access(0, 8'h00, 3, 0, 0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a    = 8'($urandom);
      if (kind == 1) begin
        sel = $urandom_range(0, 3);
        hi  = (sel == 3) ? $urandom_range(1, 100) : 64 + sel;
      end else begin
        hi = $urandom_range(1, 5);
      end
      k = 0;
      if (kind < 2 && hi > 1 && $urandom_range(0, 4) == 0)
        k = $urandom_range(1, hi - 1);
      access(kind, a, hi, k, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) clear_errs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
